// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the AES key-request arbiter slice.
//   - aes_key_t        : one round key as an 8-bit x rows x cols matrix
//   - aes_arb_state_t  : arbiter FSM states
//   - AES_MAX_ROUND    : highest legal round-key selector
//   - AES_SEL_W        : width of a round-key selector
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_NO_ROWS   = 4;
    localparam int AES_NO_COLS   = 4;
    localparam int AES_MAX_ROUND = 10;
    localparam int AES_SEL_W     = 4;

    typedef logic [AES_NO_ROWS-1:0][AES_NO_COLS-1:0][7:0] aes_key_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_VLD = 2'd1,
        DELIVER  = 2'd2
    } aes_arb_state_t;

endpackage

// File: rtl/aes_key_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// aes_key_req_arbiter_if
// Bundles the encryption-core, decryption-core and key-expander handshakes.
//   slave  : arbiter side (takes core requests and expander answers,
//            drives keys/valids back to the cores and requests to the expander)
//   master : environment side (cores + expander)
// ---------------------------------------------------------------------------
interface aes_key_req_arbiter_if #(
    parameter int NO_ROWS = aes_pkg::AES_NO_ROWS,
    parameter int NO_COLS = aes_pkg::AES_NO_COLS
);
    // encryption core
    logic                                 en_key_req_i;
    logic [aes_pkg::AES_SEL_W-1:0]        en_key_sel_i;
    logic                                 en_key_vld_o;
    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] en_cipher_key_o;
    // decryption core
    logic                                 de_key_req_i;
    logic [aes_pkg::AES_SEL_W-1:0]        de_key_sel_i;
    logic                                 de_key_vld_o;
    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] de_cipher_key_o;
    // key expander
    logic                                 exp_key_req_o;
    logic [aes_pkg::AES_SEL_W-1:0]        exp_key_sel_o;
    logic                                 exp_key_vld_i;
    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] exp_cipher_key_i;

    modport slave (
        input  en_key_req_i, en_key_sel_i, de_key_req_i, de_key_sel_i,
               exp_key_vld_i, exp_cipher_key_i,
        output en_key_vld_o, en_cipher_key_o, de_key_vld_o, de_cipher_key_o,
               exp_key_req_o, exp_key_sel_o
    );

    modport master (
        output en_key_req_i, en_key_sel_i, de_key_req_i, de_key_sel_i,
               exp_key_vld_i, exp_cipher_key_i,
        input  en_key_vld_o, en_cipher_key_o, de_key_vld_o, de_cipher_key_o,
               exp_key_req_o, exp_key_sel_o
    );
endinterface

// File: rtl/aes_rr_arb2.sv
// ---------------------------------------------------------------------------
// aes_rr_arb2
// Two-requester round-robin picker. Index 0 = encryption, 1 = decryption.
//   clk, srst   : clock, synchronous active-high reset
//   i_en        : picker may grant this cycle
//   i_req[1:0]  : pending requests
//   o_gnt_vld   : a grant is issued this cycle
//   o_gnt_idx   : index of the granted requester
// The priority pointer only moves on a tie; a lone requester is granted
// without disturbing whose turn the next tie is.
// ---------------------------------------------------------------------------
module aes_rr_arb2 (
    input  logic       clk,
    input  logic       srst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic       o_gnt_vld,
    output logic       o_gnt_idx
);
    logic r_prio_de;   // 1: decryption wins the next tie

    always_comb begin
        o_gnt_vld = i_en && (|i_req);
        o_gnt_idx = (&i_req) ? r_prio_de : i_req[1];
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_prio_de <= 1'b0;
        end else if (i_en && (&i_req)) begin
            r_prio_de <= ~r_prio_de;
        end
    end
endmodule

// File: rtl/aes_key_req_arbiter.sv
// ---------------------------------------------------------------------------
// aes_key_req_arbiter
// Shares one AES key expander between the encryption and decryption cores.
//   aes_clk        : clock, rising edge
//   reset          : synchronous active-high reset
//   bus (slave)    : core request/selector/valid/key and expander handshake
//   bad_sel_o      : 1-cycle pulse, a request carried a selector > MAX_ROUND
//   exp_timeout_o  : 1-cycle pulse, expander did not answer in time
// Port 0 = encryption core, port 1 = decryption core.
// ---------------------------------------------------------------------------
module aes_key_req_arbiter
    import aes_pkg::*;
#(
    parameter int NO_ROWS        = AES_NO_ROWS,
    parameter int NO_COLS        = AES_NO_COLS,
    parameter int MAX_ROUND      = AES_MAX_ROUND,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   aes_clk,
    input  logic                   reset,
    aes_key_req_arbiter_if.slave   bus,
    output logic                   bad_sel_o,
    output logic                   exp_timeout_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    typedef logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] key_t;

    logic [1:0]           w_req;
    logic [AES_SEL_W-1:0] w_sel [2];
    logic [1:0]           w_pending;
    logic [1:0]           w_bad_new;
    logic                 w_gnt_vld;
    logic                 w_gnt_idx;

    // served doubles as the core's registered key-valid: it is set on
    // delivery and cleared under exactly the conditions that drop valid.
    logic                 r_served     [2];
    logic [AES_SEL_W-1:0] r_served_sel [2];
    key_t                 r_key        [2];
    logic                 r_bad_seen   [2];
    logic [AES_SEL_W-1:0] r_bad_sel    [2];

    aes_arb_state_t       r_state;
    logic                 r_gnt_idx;
    logic [AES_SEL_W-1:0] r_exp_sel;
    logic                 r_exp_req;
    key_t                 r_exp_key;
    logic [CNT_W-1:0]     r_tmo_cnt;
    logic                 r_tmo_pulse;
    logic                 r_bad_pulse;

    assign w_req    = {bus.de_key_req_i, bus.en_key_req_i};
    assign w_sel[0] = bus.en_key_sel_i;
    assign w_sel[1] = bus.de_key_sel_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic w_legal;
            logic w_dlv_hit;

            assign w_legal       = (w_sel[gi] <= AES_SEL_W'(MAX_ROUND));
            assign w_pending[gi] = w_req[gi] && w_legal &&
                                   !(r_served[gi] && (r_served_sel[gi] == w_sel[gi]));
            // Report an illegal selector once per (request, selector) episode.
            assign w_bad_new[gi] = w_req[gi] && !w_legal &&
                                   !(r_bad_seen[gi] && (r_bad_sel[gi] == w_sel[gi]));
            // Deliver only if the winner still wants the key it asked for.
            assign w_dlv_hit     = (r_state == DELIVER) && (r_gnt_idx == 1'(gi)) &&
                                   w_req[gi] && (w_sel[gi] == r_exp_sel);

            always_ff @(posedge aes_clk) begin
                if (reset) begin
                    r_served[gi]     <= 1'b0;
                    r_served_sel[gi] <= '0;
                    r_key[gi]        <= '0;
                    r_bad_seen[gi]   <= 1'b0;
                    r_bad_sel[gi]    <= '0;
                end else begin
                    r_bad_seen[gi] <= w_req[gi] && !w_legal;
                    r_bad_sel[gi]  <= w_sel[gi];
                    if (w_dlv_hit) begin
                        r_served[gi]     <= 1'b1;
                        r_served_sel[gi] <= w_sel[gi];
                        r_key[gi]        <= r_exp_key;
                    end else if (!w_req[gi] || (w_sel[gi] != r_served_sel[gi])) begin
                        r_served[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    aes_rr_arb2 u_arb (
        .clk       (aes_clk),
        .srst      (reset),
        .i_en      (r_state == IDLE),
        .i_req     (w_pending),
        .o_gnt_vld (w_gnt_vld),
        .o_gnt_idx (w_gnt_idx)
    );

    always_ff @(posedge aes_clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gnt_idx   <= 1'b0;
            r_exp_sel   <= '0;
            r_exp_req   <= 1'b0;
            r_exp_key   <= '0;
            r_tmo_cnt   <= '0;
            r_tmo_pulse <= 1'b0;
            r_bad_pulse <= 1'b0;
        end else begin
            r_tmo_pulse <= 1'b0;
            r_bad_pulse <= |w_bad_new;
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_gnt_idx <= w_gnt_idx;
                        r_exp_sel <= w_sel[w_gnt_idx];
                        r_exp_req <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= WAIT_VLD;
                    end
                end
                WAIT_VLD: begin
                    // Valid is checked first so it wins over a same-cycle timeout.
                    if (bus.exp_key_vld_i) begin
                        r_exp_key <= bus.exp_cipher_key_i;
                        r_exp_req <= 1'b0;
                        r_state   <= DELIVER;
                    end else if (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Last of TIMEOUT_CYCLES waiting cycles without an answer.
                        r_tmo_pulse <= 1'b1;
                        r_exp_req   <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                DELIVER: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.en_key_vld_o    = r_served[0];
    assign bus.en_cipher_key_o = r_key[0];
    assign bus.de_key_vld_o    = r_served[1];
    assign bus.de_cipher_key_o = r_key[1];
    assign bus.exp_key_req_o   = r_exp_req;
    assign bus.exp_key_sel_o   = r_exp_sel;
    assign bad_sel_o           = r_bad_pulse;
    assign exp_timeout_o       = r_tmo_pulse;
endmodule

// File: tb/tb_aes_key_req_arbiter.sv
module tb_aes_key_req_arbiter;
    logic clk;
    logic reset;
    logic bad_sel_o;
    logic exp_timeout_o;
    int   n_checks;
    int   n_fail;
    bit   exp_mute;
    int   exp_lat;
    int   exp_cnt;

    aes_key_req_arbiter_if bus ();

    aes_key_req_arbiter dut (
        .aes_clk       (clk),
        .reset         (reset),
        .bus           (bus),
        .bad_sel_o     (bad_sel_o),
        .exp_timeout_o (exp_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] key_of(input logic [3:0] s);
        logic [127:0] base;
        base = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        return base ^ {16{{4'h0, s}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expander: raises valid for one cycle in waiting cycle exp_lat+1.
    initial begin
        bus.exp_key_vld_i    = 1'b0;
        bus.exp_cipher_key_i = '0;
        exp_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            bus.exp_key_vld_i = 1'b0;
            if (bus.exp_key_req_o && !exp_mute && !reset) begin
                if (exp_cnt == exp_lat) begin
                    bus.exp_key_vld_i    = 1'b1;
                    bus.exp_cipher_key_i = key_of(bus.exp_key_sel_o);
                    exp_cnt = 0;
                end else begin
                    exp_cnt++;
                end
            end else begin
                exp_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_vld(input bit de, input int max, output int cycles);
        cycles = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if ((de ? bus.de_key_vld_o : bus.en_key_vld_o) === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.en_key_req_i = 1'b0; bus.en_key_sel_i = '0;
        bus.de_key_req_i = 1'b0; bus.de_key_sel_i = '0;
        exp_mute = 1'b0; exp_lat = 2;
        tick(); tick();
        n_checks++; if (bus.en_key_vld_o !== 1'b0) begin n_fail++; $display("FAIL rst_en_vld: got %b want 0", bus.en_key_vld_o); end
        n_checks++; if (bus.de_key_vld_o !== 1'b0) begin n_fail++; $display("FAIL rst_de_vld: got %b want 0", bus.de_key_vld_o); end
        n_checks++; if (bus.en_cipher_key_o !== 128'h0) begin n_fail++; $display("FAIL rst_en_key: got %h want 0", bus.en_cipher_key_o); end
        n_checks++; if (bus.de_cipher_key_o !== 128'h0) begin n_fail++; $display("FAIL rst_de_key: got %h want 0", bus.de_cipher_key_o); end
        n_checks++; if ({bus.exp_key_req_o, bus.exp_key_sel_o} !== 5'h0) begin n_fail++; $display("FAIL rst_exp: got req=%b sel=%0d want 0/0", bus.exp_key_req_o, bus.exp_key_sel_o); end
        n_checks++; if ({bad_sel_o, exp_timeout_o} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses: got bad=%b tmo=%b want 0/0", bad_sel_o, exp_timeout_o); end
        reset = 1'b0;
        tick();
        $display("reset: outputs checked after synchronous reset");
    endtask

    task automatic test_enc_only();
        int cyc;
        logic [127:0] k;
        exp_lat = 2;
        bus.en_key_req_i = 1'b1; bus.en_key_sel_i = 4'd0;
        tick();
        n_checks++; if ({bus.exp_key_req_o, bus.exp_key_sel_o} !== {1'b1, 4'd0}) begin n_fail++; $display("FAIL enc_exp_req: got req=%b sel=%0d want 1/0", bus.exp_key_req_o, bus.exp_key_sel_o); end
        wait_vld(1'b0, 20, cyc);
        // 3 waiting cycles, DELIVER, then registered valid
        n_checks++; if (cyc != 4) begin n_fail++; $display("FAIL enc_latency: got %0d want 4", cyc); end
        n_checks++; if (bus.en_cipher_key_o !== key_of(4'd0)) begin n_fail++; $display("FAIL enc_key: got %h want %h", bus.en_cipher_key_o, key_of(4'd0)); end
        k = bus.en_cipher_key_o;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if ({bus.en_key_vld_o, bus.exp_key_req_o} !== 2'b10 || bus.en_cipher_key_o !== k) begin n_fail++; $display("FAIL enc_hold: got vld=%b exp_req=%b key=%h want 1/0/%h", bus.en_key_vld_o, bus.exp_key_req_o, bus.en_cipher_key_o, k); end
        end
        bus.en_key_req_i = 1'b0;
        tick();
        n_checks++; if (bus.en_key_vld_o !== 1'b0) begin n_fail++; $display("FAIL enc_drop_vld: got %b want 0", bus.en_key_vld_o); end
        n_checks++; if (bus.en_cipher_key_o !== key_of(4'd0)) begin n_fail++; $display("FAIL enc_key_keep: got %h want %h", bus.en_cipher_key_o, key_of(4'd0)); end
        $display("enc_only: sel=0 key=%h latency=%0d", k, cyc);
    endtask

    task automatic test_tie();
        int cyc;
        bus.en_key_req_i = 1'b1; bus.en_key_sel_i = 4'd1;
        bus.de_key_req_i = 1'b1; bus.de_key_sel_i = 4'd10;
        tick();
        n_checks++; if (bus.exp_key_sel_o !== 4'd1) begin n_fail++; $display("FAIL tie1_winner: got sel=%0d want 1", bus.exp_key_sel_o); end
        wait_vld(1'b0, 20, cyc);
        n_checks++; if (cyc < 0 || bus.en_cipher_key_o !== key_of(4'd1)) begin n_fail++; $display("FAIL tie1_en_key: got %h cyc=%0d want %h", bus.en_cipher_key_o, cyc, key_of(4'd1)); end
        wait_vld(1'b1, 20, cyc);
        n_checks++; if (cyc < 0 || bus.de_cipher_key_o !== key_of(4'd10)) begin n_fail++; $display("FAIL tie1_de_key: got %h cyc=%0d want %h", bus.de_cipher_key_o, cyc, key_of(4'd10)); end
        n_checks++; if (bus.en_key_vld_o !== 1'b1) begin n_fail++; $display("FAIL tie1_en_keep: got %b want 1", bus.en_key_vld_o); end
        bus.en_key_req_i = 1'b0; bus.de_key_req_i = 1'b0;
        tick(); tick();
        bus.en_key_req_i = 1'b1; bus.en_key_sel_i = 4'd2;
        bus.de_key_req_i = 1'b1; bus.de_key_sel_i = 4'd3;
        tick();
        n_checks++; if (bus.exp_key_sel_o !== 4'd3) begin n_fail++; $display("FAIL tie2_winner: got sel=%0d want 3", bus.exp_key_sel_o); end
        wait_vld(1'b1, 20, cyc);
        n_checks++; if (cyc < 0 || bus.de_cipher_key_o !== key_of(4'd3)) begin n_fail++; $display("FAIL tie2_de_key: got %h cyc=%0d want %h", bus.de_cipher_key_o, cyc, key_of(4'd3)); end
        wait_vld(1'b0, 20, cyc);
        n_checks++; if (cyc < 0 || bus.en_cipher_key_o !== key_of(4'd2)) begin n_fail++; $display("FAIL tie2_en_key: got %h cyc=%0d want %h", bus.en_cipher_key_o, cyc, key_of(4'd2)); end
        bus.en_key_req_i = 1'b0; bus.de_key_req_i = 1'b0;
        tick(); tick();
        $display("tie: first tie to encryption, second tie to decryption");
    endtask

    task automatic test_sweep();
        int cyc;
        exp_lat = 0;
        bus.en_key_req_i = 1'b1;
        for (int s = 0; s <= 10; s++) begin
            bus.en_key_sel_i = 4'(s);
            tick();
            n_checks++; if ({bus.en_key_vld_o, bus.exp_key_req_o} !== 2'b01 || bus.exp_key_sel_o !== 4'(s)) begin n_fail++; $display("FAIL sweep_start[%0d]: got vld=%b req=%b sel=%0d want 0/1/%0d", s, bus.en_key_vld_o, bus.exp_key_req_o, bus.exp_key_sel_o, s); end
            cyc = -1;
            for (int i = 1; i <= 10; i++) begin
                tick();
                if (bus.en_key_vld_o === 1'b1) begin cyc = i; break; end
            end
            n_checks++; if (cyc < 0 || bus.en_cipher_key_o !== key_of(4'(s))) begin n_fail++; $display("FAIL sweep_key[%0d]: got %h cyc=%0d want %h", s, bus.en_cipher_key_o, cyc, key_of(4'(s))); end
            $display("sweep: sel=%0d key=%h", s, bus.en_cipher_key_o);
        end
        bus.en_key_req_i = 1'b0;
        tick(); tick();
    endtask

    task automatic test_bad_sel();
        bus.de_key_req_i = 1'b1; bus.de_key_sel_i = 4'd12;
        tick();
        n_checks++; if (bad_sel_o !== 1'b1) begin n_fail++; $display("FAIL bad_pulse: got %b want 1", bad_sel_o); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if ({bad_sel_o, bus.exp_key_req_o, bus.de_key_vld_o} !== 3'b000) begin n_fail++; $display("FAIL bad_quiet: got bad=%b req=%b vld=%b want 0/0/0", bad_sel_o, bus.exp_key_req_o, bus.de_key_vld_o); end
        end
        bus.de_key_sel_i = 4'd13;
        tick();
        n_checks++; if (bad_sel_o !== 1'b1) begin n_fail++; $display("FAIL bad_resel: got %b want 1", bad_sel_o); end
        bus.de_key_req_i = 1'b0;
        tick(); tick();
        $display("bad_sel: sel=12 and sel=13 rejected");
    endtask

    task automatic test_timeout();
        int cyc;
        int req_low;
        exp_mute = 1'b1;
        bus.en_key_req_i = 1'b1; bus.en_key_sel_i = 4'd5;
        tick();
        cyc = -1; req_low = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (exp_timeout_o === 1'b1) begin cyc = i; break; end
            if (bus.exp_key_req_o !== 1'b1) req_low++;
        end
        n_checks++; if (cyc != 64 || req_low != 0) begin n_fail++; $display("FAIL tmo_cycle: got %0d (req low %0d) want 64 (0)", cyc, req_low); end
        n_checks++; if (bus.exp_key_req_o !== 1'b0) begin n_fail++; $display("FAIL tmo_req_drop: got %b want 0", bus.exp_key_req_o); end
        exp_mute = 1'b0; exp_lat = 1;
        tick();
        n_checks++; if ({bus.exp_key_req_o, exp_timeout_o, bus.exp_key_sel_o} !== {2'b10, 4'd5}) begin n_fail++; $display("FAIL tmo_retry: got req=%b tmo=%b sel=%0d want 1/0/5", bus.exp_key_req_o, exp_timeout_o, bus.exp_key_sel_o); end
        wait_vld(1'b0, 20, cyc);
        n_checks++; if (cyc < 0 || bus.en_cipher_key_o !== key_of(4'd5)) begin n_fail++; $display("FAIL tmo_retry_key: got %h cyc=%0d want %h", bus.en_cipher_key_o, cyc, key_of(4'd5)); end
        bus.en_key_req_i = 1'b0;
        tick(); tick();
        $display("timeout: pulse after 64 waiting cycles, retry delivered");
    endtask

    task automatic test_vld_vs_timeout();
        int cyc;
        int tmo_seen;
        exp_lat = 63;   // valid lands in the 64th waiting cycle
        bus.en_key_req_i = 1'b1; bus.en_key_sel_i = 4'd6;
        tick();
        cyc = -1; tmo_seen = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (exp_timeout_o === 1'b1) tmo_seen++;
            if (bus.en_key_vld_o === 1'b1) begin cyc = i; break; end
        end
        n_checks++; if (tmo_seen != 0 || cyc != 65) begin n_fail++; $display("FAIL vld_wins: got tmo=%0d cyc=%0d want 0/65", tmo_seen, cyc); end
        n_checks++; if (bus.en_cipher_key_o !== key_of(4'd6)) begin n_fail++; $display("FAIL vld_wins_key: got %h want %h", bus.en_cipher_key_o, key_of(4'd6)); end
        bus.en_key_req_i = 1'b0;
        exp_lat = 2;
        tick(); tick();
        $display("vld_vs_timeout: valid in last waiting cycle wins");
    endtask

    task automatic test_reset_mid();
        int cyc;
        bus.de_key_req_i = 1'b1; bus.de_key_sel_i = 4'd4;
        wait_vld(1'b1, 20, cyc);
        n_checks++; if (cyc < 0 || bus.de_cipher_key_o !== key_of(4'd4)) begin n_fail++; $display("FAIL mid_de_key: got %h want %h", bus.de_cipher_key_o, key_of(4'd4)); end
        exp_mute = 1'b1;
        bus.en_key_req_i = 1'b1; bus.en_key_sel_i = 4'd7;
        tick();
        n_checks++; if ({bus.exp_key_req_o, bus.exp_key_sel_o} !== {1'b1, 4'd7}) begin n_fail++; $display("FAIL mid_exp_req: got req=%b sel=%0d want 1/7", bus.exp_key_req_o, bus.exp_key_sel_o); end
        tick(); tick();
        reset = 1'b1;
        tick();
        n_checks++; if ({bus.exp_key_req_o, bus.exp_key_sel_o, bus.en_key_vld_o, bus.de_key_vld_o, exp_timeout_o, bad_sel_o} !== 9'h0) begin n_fail++; $display("FAIL mid_rst_ctrl: got req=%b sel=%0d env=%b dev=%b want all 0", bus.exp_key_req_o, bus.exp_key_sel_o, bus.en_key_vld_o, bus.de_key_vld_o); end
        n_checks++; if (bus.de_cipher_key_o !== 128'h0) begin n_fail++; $display("FAIL mid_rst_key: got %h want 0", bus.de_cipher_key_o); end
        reset = 1'b0;
        bus.en_key_req_i = 1'b0; bus.de_key_req_i = 1'b0;
        exp_mute = 1'b0;
        tick();
        $display("reset_mid: in-flight transaction abandoned");
    endtask

    task automatic test_drop_during_wait();
        int bad_vld;
        int cyc;
        exp_lat = 3;
        bus.en_key_req_i = 1'b1; bus.en_key_sel_i = 4'd8;
        tick();
        n_checks++; if (bus.exp_key_req_o !== 1'b1) begin n_fail++; $display("FAIL drop_exp_req: got %b want 1", bus.exp_key_req_o); end
        tick();
        bus.en_key_req_i = 1'b0;
        bad_vld = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.en_key_vld_o !== 1'b0) bad_vld++;
        end
        n_checks++; if (bad_vld != 0 || bus.exp_key_req_o !== 1'b0) begin n_fail++; $display("FAIL drop_no_vld: got vld cycles=%0d req=%b want 0/0", bad_vld, bus.exp_key_req_o); end
        n_checks++; if (bus.en_cipher_key_o !== 128'h0) begin n_fail++; $display("FAIL drop_key_discard: got %h want 0", bus.en_cipher_key_o); end
        // the discarded key must not count as served: same sel goes out again
        bus.en_key_req_i = 1'b1;
        tick();
        n_checks++; if ({bus.exp_key_req_o, bus.exp_key_sel_o} !== {1'b1, 4'd8}) begin n_fail++; $display("FAIL drop_rerequest: got req=%b sel=%0d want 1/8", bus.exp_key_req_o, bus.exp_key_sel_o); end
        wait_vld(1'b0, 20, cyc);
        n_checks++; if (cyc < 0 || bus.en_cipher_key_o !== key_of(4'd8)) begin n_fail++; $display("FAIL drop_rerequest_key: got %h want %h", bus.en_cipher_key_o, key_of(4'd8)); end
        bus.en_key_req_i = 1'b0;
        tick();
        $display("drop_during_wait: key discarded, re-request delivered");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_enc_only();
        test_tie();
        test_sweep();
        test_bad_sel();
        test_timeout();
        test_vld_vs_timeout();
        test_reset_mid();
        test_drop_during_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
